// File: rtl/alu_seq_param_if.sv
// Request/response bundle between the control unit and the sequential ALU.
// The control unit takes the master side and the ALU takes the slave side.
interface alu_seq_param_if #(
   parameter int WIDTH = 32
);
   localparam int SHAMT_W = $clog2(WIDTH);

   logic               in_valid;
   logic               in_ready;
   logic [2:0]         op;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic [SHAMT_W-1:0] shamt;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   result;
   logic               carry;
   logic               msb;
   logic               zero;

   modport master (
      output in_valid, op, a, b, shamt, out_ready,
      input  in_ready, out_valid, result, carry, msb, zero
   );

   modport slave (
      input  in_valid, op, a, b, shamt, out_ready,
      output in_ready, out_valid, result, carry, msb, zero
   );
endinterface

// File: rtl/alu_seq_param.sv
// Handshaked ALU: single-cycle arithmetic/logic ops, iterative STEP-bit shifter.
// The result register doubles as the shift working register.
module alu_seq_param #(
   parameter int WIDTH = 32,
   parameter int STEP  = 1
) (
   input  logic          clk,
   input  logic          rst,
   alu_seq_param_if.slave bus
);
   localparam int SHAMT_W = $clog2(WIDTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_XOR  = 3'b011;
   localparam logic [2:0] OP_DIFF = 3'b100;
   localparam logic [2:0] OP_SLL  = 3'b101;
   localparam logic [2:0] OP_SRA  = 3'b111;

   localparam logic [SHAMT_W:0] STEP_C = (SHAMT_W+1)'(STEP);
   localparam logic [WIDTH:0]   ONE_C  = (WIDTH+1)'(1);

   logic [1:0]         state_q, state_d;
   logic               in_ready_q;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               carry_q, carry_d;
   logic               zero_q;
   logic [SHAMT_W-1:0] rem_q, rem_d;
   logic [2:0]         op_q, op_d;

   // Single-cycle datapath, driven straight from the request inputs.
   logic [WIDTH:0]   add_sum;
   logic [WIDTH:0]   sub_sum;
   logic [WIDTH-1:0] diff_x;
   logic [WIDTH-1:0] diff_idx;

   assign add_sum = {1'b0, bus.a} + {1'b0, bus.b};
   assign sub_sum = {1'b0, bus.a} + {1'b0, ~bus.b} + ONE_C;
   assign diff_x  = bus.a ^ bus.b;

   always_comb begin
      diff_idx = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (diff_x[i]) diff_idx = WIDTH'(i);
      end
   end

   // One shifter pass: move by min(STEP, remaining); the extra bit catches the last bit out.
   logic [SHAMT_W:0] rem_ext;
   logic [SHAMT_W:0] amt;
   logic [SHAMT_W:0] rem_after;
   logic [WIDTH:0]   sll_full;
   logic [WIDTH:0]   sr_src;
   logic [WIDTH:0]   srl_full;
   logic [WIDTH:0]   sra_full;

   assign rem_ext   = {1'b0, rem_q};
   assign amt       = (rem_ext > STEP_C) ? STEP_C : rem_ext;
   assign rem_after = rem_ext - amt;
   assign sll_full  = {1'b0, result_q} << amt;
   assign sr_src    = {result_q, 1'b0};
   assign srl_full  = sr_src >> amt;
   // NOTE: >>> only sign-fills when its operand is signed; mixing it with an unsigned arm of a ?: would silently make it logical.
   assign sra_full  = $signed(sr_src) >>> amt;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      carry_d  = carry_q;
      rem_d    = rem_q;
      op_d     = op_q;
      case (state_q)
         S_IDLE: begin
            if (bus.in_valid && in_ready_q) begin
               op_d    = bus.op;
               carry_d = 1'b0;
               state_d = S_DONE;
               case (bus.op)
                  OP_ADD: {carry_d, result_d} = add_sum;
                  OP_SUB: {carry_d, result_d} = sub_sum;
                  OP_AND: result_d = bus.a & bus.b;
                  OP_XOR: result_d = diff_x;
                  OP_DIFF: begin
                     if (bus.a == bus.b) begin
                        result_d = '1;
                        carry_d  = 1'b1;
                     end else begin
                        result_d = diff_idx;
                     end
                  end
                  default: begin
                     result_d = bus.a;
                     if (bus.shamt != '0) begin
                        rem_d   = bus.shamt;
                        state_d = S_SHIFT;
                     end
                  end
               endcase
            end
         end
         S_SHIFT: begin
            if (op_q == OP_SLL) begin
               {carry_d, result_d} = sll_full;
            end else if (op_q == OP_SRA) begin
               {result_d, carry_d} = sra_full;
            end else begin
               {result_d, carry_d} = srl_full;
            end
            rem_d = rem_after[SHAMT_W-1:0];
            if (rem_after == '0) state_d = S_DONE;
         end
         S_DONE: begin
            if (bus.out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         in_ready_q <= 1'b0;
         result_q   <= '0;
         carry_q    <= 1'b0;
         zero_q     <= 1'b0;
         rem_q      <= '0;
         op_q       <= OP_ADD;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d == S_IDLE);
         result_q   <= result_d;
         carry_q    <= carry_d;
         zero_q     <= (result_d == '0);
         rem_q      <= rem_d;
         op_q       <= op_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = (state_q == S_DONE);
   assign bus.result    = result_q;
   assign bus.carry     = carry_q;
   assign bus.msb       = result_q[WIDTH-1];
   assign bus.zero      = zero_q;
endmodule

// File: tb/tb_alu_seq_param.sv
// Scoreboarded directed/random bench for alu_seq_param at 32/1 and 16/4.
module tb_alu_seq_param;
   typedef struct {
      logic [31:0] r;
      logic        c;
      int          lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   alu_seq_param_if #(.WIDTH(32)) bus32 ();
   alu_seq_param_if #(.WIDTH(16)) bus16 ();

   alu_seq_param #(.WIDTH(32), .STEP(1)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));
   alu_seq_param #(.WIDTH(16), .STEP(4)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] r, input logic c, input int lat);
      exp_t e;
      e.r = r; e.c = c; e.lat = lat;
      return e;
   endfunction

   // Reference model on 64-bit arithmetic, masked to the instance width.
   function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input int k, input int width, input int step);
      logic [63:0] mask, aa, bb, s, x, sa;
      exp_t e;
      mask = (64'd1 << width) - 64'd1;
      aa = {32'h0, a} & mask;
      bb = {32'h0, b} & mask;
      s = '0;
      e.c = 1'b0;
      e.lat = 1;
      case (op)
         3'd0: begin s = aa + bb; e.c = s[width]; s = s & mask; end
         3'd1: begin s = aa + (~bb & mask) + 64'd1; e.c = s[width]; s = s & mask; end
         3'd2: s = aa & bb;
         3'd3: s = aa ^ bb;
         3'd4: begin
            x = aa ^ bb;
            if (x == 0) begin
               s = mask; e.c = 1'b1;
            end else begin
               for (int i = width - 1; i >= 0; i--) if (x[i]) s = 64'(i);
            end
         end
         3'd5: begin s = (aa << k) & mask; if (k > 0) e.c = aa[width-k]; end
         3'd6: begin s = aa >> k; if (k > 0) e.c = aa[k-1]; end
         default: begin
            sa = aa[width-1] ? (aa | ~mask) : aa;
            s = (sa >> k) & mask;
            if (k > 0) e.c = aa[k-1];
         end
      endcase
      if (op >= 3'd5 && k > 0) e.lat = (k + step - 1) / step + 1;
      e.r = s[31:0];
      return e;
   endfunction

   function automatic logic [31:0] get_res(input bit sel);
      return sel ? {16'h0, bus16.result} : bus32.result;
   endfunction

   // {in_ready, out_valid, carry, msb, zero}
   function automatic logic [4:0] get_flags(input bit sel);
      return sel ? {bus16.in_ready, bus16.out_valid, bus16.carry, bus16.msb, bus16.zero}
                 : {bus32.in_ready, bus32.out_valid, bus32.carry, bus32.msb, bus32.zero};
   endfunction

   task automatic drive(input bit sel, input logic v, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b, input int k);
      if (sel) begin
         bus16.in_valid = v; bus16.op = op; bus16.a = a[15:0]; bus16.b = b[15:0]; bus16.shamt = k[3:0];
      end else begin
         bus32.in_valid = v; bus32.op = op; bus32.a = a; bus32.b = b; bus32.shamt = k[4:0];
      end
   endtask

   task automatic set_out_ready(input logic v);
      bus32.out_ready = v;
      bus16.out_ready = v;
   endtask

   task automatic run_op(input bit sel, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int k, input exp_t e, input int hold);
      int n;
      exp_t got;
      logic [4:0] fl;
      string tg;
      tg = sel ? "w16" : "w32";
      n = 0;
      while (get_flags(sel)[4] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      check({tg, "_in_ready"}, 32'(get_flags(sel)[4]), 32'd1);
      drive(sel, 1'b1, op, a, b, k);
      sb_q.push_back(e);
      @(negedge clk);
      drive(sel, 1'b0, 3'b000, 32'h0, 32'h0, 0);
      n = 1;
      while (get_flags(sel)[3] !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      got = sb_q.pop_front();
      fl = get_flags(sel);
      check({tg, "_out_valid"}, 32'(fl[3]), 32'd1);
      check({tg, "_latency"}, 32'(n), 32'(got.lat));
      check({tg, "_result"}, get_res(sel), got.r);
      check({tg, "_carry"}, 32'(fl[2]), 32'(got.c));
      check({tg, "_msb"}, 32'(fl[1]), 32'(sel ? got.r[15] : got.r[31]));
      check({tg, "_zero"}, 32'(fl[0]), 32'(got.r == 32'h0));
      for (int h = 0; h < hold; h++) begin
         drive(sel, 1'b1, 3'b000, ~a, b, 0);
         @(negedge clk);
         check({tg, "_hold_result"}, get_res(sel), got.r);
         check({tg, "_hold_in_ready"}, 32'(get_flags(sel)[4]), 32'd0);
         check({tg, "_hold_out_valid"}, 32'(get_flags(sel)[3]), 32'd1);
      end
      drive(sel, 1'b0, 3'b000, 32'h0, 32'h0, 0);
      set_out_ready(1'b1);
      @(negedge clk);
      set_out_ready(1'b0);
      check({tg, "_out_valid_after_xfer"}, 32'(get_flags(sel)[3]), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      int          rk, n;

      drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 0);
      drive(1'b1, 1'b0, 3'b000, 32'h0, 32'h0, 0);
      set_out_ready(1'b0);

      #1;
      check("rst_in_ready", 32'(bus32.in_ready), 32'd0);
      check("rst_out_valid", 32'(bus32.out_valid), 32'd0);
      check("rst_result", bus32.result, 32'h0);
      check("rst_flags", 32'({bus32.carry, bus32.msb, bus32.zero}), 32'd0);
      check("rst_w16_in_ready", 32'(bus16.in_ready), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", 32'(bus32.in_ready), 32'd1);

      // Abort an sll in its fifth SHIFT cycle.
      drive(1'b0, 1'b1, 3'b101, 32'h1, 32'h0, 20);
      @(negedge clk);
      drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 0);
      for (int i = 0; i < 4; i++) @(negedge clk);
      check("mid_shift_not_valid", 32'(bus32.out_valid), 32'd0);
      rst = 1'b1;
      #1;
      check("abort_out_valid", 32'(bus32.out_valid), 32'd0);
      check("abort_result", bus32.result, 32'h0);
      check("abort_in_ready", 32'(bus32.in_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("abort_in_ready_back", 32'(bus32.in_ready), 32'd1);
      n = 0;
      for (int i = 0; i < 25; i++) begin
         if (bus32.out_valid !== 1'b0) n++;
         @(negedge clk);
      end
      check("abort_no_stale", 32'(n), 32'd0);

      run_op(1'b0, 3'b000, 32'hFFFF_FFFF, 32'h1, 0, mk(32'h0, 1'b1, 1), 0);
      run_op(1'b0, 3'b001, 32'd5, 32'd7, 0, mk(32'hFFFF_FFFE, 1'b0, 1), 0);
      run_op(1'b0, 3'b001, 32'd7, 32'd5, 0, mk(32'h2, 1'b1, 1), 0);
      run_op(1'b0, 3'b111, 32'h8000_0001, 32'h0, 4, mk(32'hF800_0000, 1'b0, 5), 0);
      run_op(1'b0, 3'b110, 32'h8000_0001, 32'h0, 1, mk(32'h4000_0000, 1'b1, 2), 0);
      run_op(1'b0, 3'b101, 32'h8000_0001, 32'h0, 0, mk(32'h8000_0001, 1'b0, 1), 0);
      run_op(1'b0, 3'b100, 32'h0000_00F0, 32'h0000_0070, 0, mk(32'h7, 1'b0, 1), 0);
      run_op(1'b0, 3'b100, 32'h1234, 32'h1234, 0, mk(32'hFFFF_FFFF, 1'b1, 1), 0);
      run_op(1'b0, 3'b010, 32'hF0F0_1234, 32'h0FF0_FF00, 0, mk(32'h00F0_1200, 1'b0, 1), 0);
      run_op(1'b0, 3'b011, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 0, mk(32'hFFFF_FFFF, 1'b0, 1), 10);
      run_op(1'b0, 3'b101, 32'h0000_0003, 32'h0, 31, mk(32'h8000_0000, 1'b1, 32), 0);

      run_op(1'b1, 3'b101, 32'h0001, 32'h0, 15, mk(32'h8000, 1'b0, 5), 0);
      run_op(1'b1, 3'b000, 32'hFFFF, 32'h1, 0, mk(32'h0, 1'b1, 1), 0);
      run_op(1'b1, 3'b111, 32'h8001, 32'h0, 5, mk(32'hFC00, 1'b0, 3), 0);
      run_op(1'b1, 3'b110, 32'h00F0, 32'h0, 4, mk(32'h000F, 1'b0, 2), 4);

      for (int i = 0; i < 30; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra = $urandom;
         rb = (i % 5 == 0) ? ra : $urandom;
         rk = $urandom_range(0, 31);
         run_op(1'b0, rop, ra, rb, rk, model(rop, ra, rb, rk, 32, 1), 0);
      end
      for (int i = 0; i < 20; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra = $urandom;
         rb = (i % 5 == 0) ? ra : $urandom;
         rk = $urandom_range(0, 15);
         run_op(1'b1, rop, ra, rb, rk, model(rop, ra, rb, rk, 16, 4), 0);
      end

      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
